// File: rtl/lcd_reader.sv
// lcd_reader: HD44780-style bus reader. Issues timed read cycles on the
// LCD control pins, captures the data bus at the end of the enable pulse,
// and optionally repeats status reads until the busy flag clears.
module lcd_reader #(
  parameter int T_AS      = 3,
  parameter int T_EPW     = 25,
  parameter int T_EL      = 25,
  parameter int MAX_POLLS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic       poll,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       busy_flag,
  output logic [6:0] addr,
  output logic       timeout,
  output logic       bus_req,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [7:0] lcd_db_in
);

  localparam int TMAX = (T_AS > T_EPW) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                       : ((T_EPW > T_EL) ? T_EPW : T_EL);
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int PW   = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, E_LOW, DONE} state_t;

  state_t        state;
  logic [TW-1:0] tmr;     // clocks spent in the current timed phase
  logic [PW-1:0] polls;   // completed reads minus one; never exceeds MAX_POLLS-1
  logic          rs_q;
  logic          poll_q;
  logic          more;    // another status read is wanted and allowed

  assign more = poll_q && busy_flag && ((32'(polls) + 32'd1) < 32'(MAX_POLLS));

  // Single FSM: every pin and status output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      polls     <= '0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      busy_flag <= 1'b0;
      addr      <= 7'h00;
      timeout   <= 1'b0;
      bus_req   <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_e     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready   <= 1'b1;
          bus_req <= 1'b0;
          lcd_rw  <= 1'b0;
          lcd_e   <= 1'b0;
          if (start && ready) begin
            // polling always targets the status register
            rs_q    <= rs & ~poll;
            lcd_rs  <= rs & ~poll;
            poll_q  <= poll;
            polls   <= '0;
            tmr     <= '0;
            ready   <= 1'b0;
            bus_req <= 1'b1;
            lcd_rw  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == TW'(T_AS - 1)) begin
            tmr   <= '0;
            lcd_e <= 1'b1;
            state <= E_HIGH;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        E_HIGH: begin
          if (tmr == TW'(T_EPW - 1)) begin
            tmr   <= '0;
            lcd_e <= 1'b0;
            rdata <= lcd_db_in;
            if (!rs_q) begin
              busy_flag <= lcd_db_in[7];
              addr      <= lcd_db_in[6:0];
            end
            state <= E_LOW;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        E_LOW: begin
          if (tmr == TW'(T_EL - 1)) begin
            tmr <= '0;
            if (more) begin
              polls <= polls + 1'b1;
              state <= SETUP;
            end else begin
              done    <= 1'b1;
              bus_req <= 1'b0;
              lcd_rw  <= 1'b0;
              timeout <= poll_q & busy_flag;
              state   <= DONE;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed and randomized read scenarios against a simple
// LCD bus model; expectations come from the timing/poll rules directly.
module tb_lcd_reader;
  localparam int MAXP = 4;
  localparam int RD   = 3 + 25 + 25;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, rs = 1'b0, poll = 1'b0;
  logic [7:0] lcd_db_in = 8'h00;
  logic       ready, done, busy_flag, timeout, bus_req, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] rdata;
  logic [6:0] addr;

  int n_checks = 0, n_fail = 0;
  logic [7:0] resp [0:7];

  // results of the last run_read
  int   r_cyc, r_eh, r_pulses, r_extra;
  logic r_bus_ok, r_rw_ok, r_rdy_ok, r_rs_ok, r_rdy_after, r_timed_out;

  // model state of the sticky status outputs
  logic       m_bf = 1'b0, m_to = 1'b0;
  logic [6:0] m_addr = 7'h00;

  always #10 clk = ~clk;

  lcd_reader #(.MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs(rs), .poll(poll),
    .ready(ready), .done(done), .rdata(rdata), .busy_flag(busy_flag),
    .addr(addr), .timeout(timeout), .bus_req(bus_req), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db_in(lcd_db_in));

  // Issue one request and play the LCD: each lcd_e rise presents the next resp[].
  task automatic run_read(input logic r_s, input logic p, input logic glitch);
    logic prev_e = 1'b0;
    @(negedge clk); start = 1'b1; rs = r_s; poll = p;
    @(posedge clk); #1; start = 1'b0;
    r_cyc = 0; r_eh = 0; r_pulses = 0; r_extra = 0; r_timed_out = 1'b1;
    r_bus_ok = 1'b1; r_rw_ok = 1'b1; r_rdy_ok = 1'b1; r_rs_ok = 1'b1;
    while (r_cyc < 2000) begin
      @(posedge clk); #1; r_cyc++;
      if (lcd_e && !prev_e) begin
        lcd_db_in = resp[(r_pulses < 8) ? r_pulses : 7];
        r_pulses++;
      end
      prev_e = lcd_e;
      if (lcd_e) r_eh++;
      if (lcd_e && !lcd_rw) r_rw_ok = 1'b0;
      if (lcd_e && (lcd_rs !== (r_s & ~p))) r_rs_ok = 1'b0;
      if (ready) r_rdy_ok = 1'b0;
      if (done) begin r_timed_out = 1'b0; break; end
      if (!bus_req) r_bus_ok = 1'b0;
      if (glitch) start = (r_cyc == 1);
    end
    @(posedge clk); #1;
    r_rdy_after = ready;
    if (glitch) begin
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (done) r_extra++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({lcd_e, lcd_rw, lcd_rs, bus_req, done, timeout} !== 6'b0) begin n_fail++; $display("FAIL reset_pins: got %b need 000000", {lcd_e, lcd_rw, lcd_rs, bus_req, done, timeout}); end
    n_checks++; if ({rdata, busy_flag, addr} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h/%b/%h need 00/0/00", rdata, busy_flag, addr); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b need 1", ready); end
  endtask

  task automatic test_data_read();
    resp[0] = 8'h41;
    run_read(1'b1, 1'b0, 1'b0);
    n_checks++; if (r_timed_out || r_cyc != RD) begin n_fail++; $display("FAIL data_latency: got %0d need %0d", r_cyc, RD); end
    n_checks++; if (r_eh != 25) begin n_fail++; $display("FAIL data_ehigh: got %0d need 25", r_eh); end
    n_checks++; if (rdata !== 8'h41) begin n_fail++; $display("FAIL data_rdata: got %h need 41", rdata); end
    n_checks++; if (busy_flag !== m_bf || addr !== m_addr) begin n_fail++; $display("FAIL data_status_kept: got %b/%h need %b/%h", busy_flag, addr, m_bf, m_addr); end
    n_checks++; if (!r_rw_ok || !r_rs_ok || !r_bus_ok) begin n_fail++; $display("FAIL data_pins: rw_ok %b rs_ok %b bus_ok %b need 111", r_rw_ok, r_rs_ok, r_bus_ok); end
    n_checks++; if (!r_rdy_ok || r_rdy_after !== 1'b1) begin n_fail++; $display("FAIL data_ready: busy_ok %b after %b need 1/1", r_rdy_ok, r_rdy_after); end
  endtask

  task automatic test_status_read();
    resp[0] = 8'h8A;
    run_read(1'b0, 1'b0, 1'b0);
    m_bf = 1'b1; m_addr = 7'h0A; m_to = 1'b0;
    n_checks++; if (r_timed_out || r_cyc != RD) begin n_fail++; $display("FAIL status_latency: got %0d need %0d", r_cyc, RD); end
    n_checks++; if (busy_flag !== 1'b1 || addr !== 7'h0A) begin n_fail++; $display("FAIL status_bf_addr: got %b/%h need 1/0a", busy_flag, addr); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL status_timeout: got %b need 0", timeout); end
    n_checks++; if (!r_rs_ok) begin n_fail++; $display("FAIL status_lcd_rs: got mismatch need lcd_rs=0"); end
  endtask

  task automatic test_poll();
    resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h05;
    run_read(1'b1, 1'b1, 1'b0);
    m_bf = 1'b0; m_addr = 7'h05; m_to = 1'b0;
    n_checks++; if (r_timed_out || r_cyc != 4 * RD) begin n_fail++; $display("FAIL poll_latency: got %0d need %0d", r_cyc, 4 * RD); end
    n_checks++; if (r_pulses != 4 || r_eh != 100) begin n_fail++; $display("FAIL poll_pulses: got %0d/%0d need 4/100", r_pulses, r_eh); end
    n_checks++; if (busy_flag !== 1'b0 || addr !== 7'h05 || timeout !== 1'b0) begin n_fail++; $display("FAIL poll_status: got %b/%h/%b need 0/05/0", busy_flag, addr, timeout); end
    n_checks++; if (!r_bus_ok || !r_rs_ok) begin n_fail++; $display("FAIL poll_bus: bus_ok %b rs_ok %b need 1/1", r_bus_ok, r_rs_ok); end
  endtask

  task automatic test_poll_timeout();
    for (int i = 0; i < 8; i++) resp[i] = 8'hFF;
    run_read(1'b0, 1'b1, 1'b0);
    m_bf = 1'b1; m_addr = 7'h7F; m_to = 1'b1;
    n_checks++; if (r_timed_out || r_cyc != 4 * RD || r_pulses != 4) begin n_fail++; $display("FAIL timeout_reads: got %0d clk %0d reads need %0d/4", r_cyc, r_pulses, 4 * RD); end
    n_checks++; if (timeout !== 1'b1 || busy_flag !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b/%b need 1/1", timeout, busy_flag); end
  endtask

  task automatic test_reset_mid();
    int eh = 0, cyc = 0;
    logic seen_done = 1'b0;
    resp[0] = 8'h5A;
    @(negedge clk); start = 1'b1; rs = 1'b1; poll = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    while (eh < 10 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (lcd_e) begin eh++; lcd_db_in = resp[0]; end
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (eh != 10 || lcd_e !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_pins: eh %0d lcd_e %b bus_req %b need 10/0/0", eh, lcd_e, bus_req); end
    @(posedge clk); #1;
    if (done) seen_done = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if (done) seen_done = 1'b1;
    n_checks++; if (seen_done) begin n_fail++; $display("FAIL rstmid_done: got done pulse need none"); end
    n_checks++; if (ready !== 1'b1 || rdata !== 8'h00 || timeout !== 1'b0 || busy_flag !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got rdy %b rdata %h to %b bf %b need 1/00/0/0", ready, rdata, timeout, busy_flag); end
    m_bf = 1'b0; m_addr = 7'h00; m_to = 1'b0;
  endtask

  task automatic test_back_to_back();
    resp[0] = 8'h33;
    run_read(1'b1, 1'b0, 1'b1);
    n_checks++; if (r_timed_out || r_cyc != RD || r_extra != 0) begin n_fail++; $display("FAIL b2b_done: got %0d clk %0d extra need %0d/0", r_cyc, r_extra, RD); end
    n_checks++; if (!r_rdy_ok || r_rdy_after !== 1'b1 || rdata !== 8'h33) begin n_fail++; $display("FAIL b2b_ready: busy_ok %b after %b rdata %h need 1/1/33", r_rdy_ok, r_rdy_after, rdata); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic r_s, p;
      int n;
      r_s = 1'($urandom % 2);
      p   = 1'($urandom % 2);
      for (int i = 0; i < 8; i++) begin
        resp[i] = 8'($urandom);
        if (p) resp[i][7] = ($urandom % 3) != 0;
      end
      // reads performed: first non-busy status, capped at MAXP
      n = 1;
      if (p) while (n < MAXP && resp[n-1][7]) n++;
      if (!(r_s & ~p)) begin m_bf = resp[n-1][7]; m_addr = resp[n-1][6:0]; end
      m_to = p & resp[n-1][7];
      run_read(r_s, p, 1'b0);
      n_checks++; if (r_timed_out || r_cyc != n * RD || r_pulses != n) begin n_fail++; $display("FAIL rand%0d_latency: got %0d clk %0d reads need %0d/%0d", it, r_cyc, r_pulses, n * RD, n); end
      n_checks++; if (rdata !== resp[n-1] || busy_flag !== m_bf || addr !== m_addr || timeout !== m_to) begin n_fail++; $display("FAIL rand%0d_out: got %h/%b/%h/%b need %h/%b/%h/%b", it, rdata, busy_flag, addr, timeout, resp[n-1], m_bf, m_addr, m_to); end
      n_checks++; if (!r_rw_ok || !r_rs_ok || !r_bus_ok) begin n_fail++; $display("FAIL rand%0d_pins: rw %b rs %b bus %b need 111", it, r_rw_ok, r_rs_ok, r_bus_ok); end
    end
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_status_read();
    test_poll();
    test_poll_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
